lc3_decode: RTL and testbench
=============================

// Module: lc3_decode
// PURPOSE
//  Decode stage of the LC-3 datapath. Sits directly downstream of the fetch stage.
//  Waits out the instruction-BRAM read latency after fetch issues an address, then latches the word into IR.
//  Splits IR into opcode, register, immediate and offset fields, sign-extended to 16 bits.
//  Drives opCode_in, offset_in and br_nzp back into fetch for PC redirection.
// PARAMETERS
//  MEM_LAT  1  instruction BRAM read latency in cycles; legal range 1..4
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  decode_start   in   1   one-cycle pulse from fetch: instruction address issued this cycle
//  flush          in   1   abort any decode in progress (branch redirect)
//  mem_dout       in   16  instruction BRAM read data
//  ir_out         out  16  latched instruction register
//  opCode_out     out  4   IR[15:12]
//  dr_out         out  3   IR[11:9]
//  sr1_out        out  3   IR[8:6]
//  sr2_out        out  3   IR[2:0]
//  imm_flag       out  1   IR[5]
//  imm5_sext      out  16  sign-extended IR[4:0]
//  off6_sext      out  16  sign-extended IR[5:0]
//  off9_out       out  9   IR[8:0] raw, feeds fetch offset_in
//  off9_sext      out  16  sign-extended IR[8:0]
//  off11_sext     out  16  sign-extended IR[10:0]
//  br_nzp_out     out  3   IR[11:9] when opcode==4'b0000, else 3'b000
//  illegal        out  1   opcode == 4'b1101 (reserved)
//  busy           out  1   high in WAIT and DONE states
//  decode_done    out  1   one-cycle pulse: all field outputs valid and stable
// BEHAVIOUR
//  Reset (rst high at a posedge): state=IDLE, wait counter=0, every output=0.
//  Reset takes priority over flush and decode_start, and also applies mid-operation.
//  FSM states: IDLE, WAIT, DONE.
//   IDLE: decode_start sampled high at edge E0 -> WAIT, cnt<=1.
//   WAIT: cnt increments each edge. At edge E0+MEM_LAT, IR<=mem_dout, all field outputs update from mem_dout, then -> DONE.
//   DONE: decode_done=1 for exactly this one cycle; next edge -> IDLE.
//  Latency: decode_done is high between edges E0+MEM_LAT and E0+MEM_LAT+1.
//  Next accepted decode_start is at edge E0+MEM_LAT+2 or later.
//  decode_start sampled while busy (WAIT or DONE) is ignored: no queueing, no error.
//  flush high at an edge while in WAIT or DONE:
//   state -> IDLE, decode_done forced 0, IR and field outputs keep their previous values.
//   A decode_start on that same edge is ignored.
//  flush in IDLE has no effect. When flush and decode_start are both high in IDLE, flush wins: start is dropped.
//  Field outputs are registered and change only at the IR-capture edge. They hold until the next capture or reset.
//  Sign extension replicates the field MSB up to bit 15. No other arithmetic is done here.
//  illegal is registered alongside IR and holds with it. Stage behaviour is unchanged on an illegal opcode.
//  busy is combinational from state: busy = (state != IDLE).
// TESTING
//  1. rst=1 for 5 clks, then release -> all outputs 0, busy=0, decode_done=0.
//  2. BRp: MEM_LAT=1, start at E0, mem_dout=16'h0203 -> at E0+1: opCode_out=0, br_nzp_out=3'b001, off9_out=9'h003, off9_sext=16'h0003; decode_done high for 1 cycle.
//  3. ADD R5,R1,#-1: mem_dout=16'h1A7F -> dr_out=5, sr1_out=1, imm_flag=1, imm5_sext=16'hFFFF, br_nzp_out=0; negative BR 16'h0FFF -> off9_sext=16'hFFFF.
//  4. Illegal opcode: mem_dout=16'hD000 -> illegal=1, decode_done still pulses; then 16'h0203 -> illegal=0.
//  5. MEM_LAT=3: start, then start again 1 cycle later -> second start ignored, exactly one decode_done at E0+3; flush at E0+2 instead -> no decode_done, IR unchanged.
//  6. Reset mid-WAIT -> next cycle state IDLE, outputs 0, no decode_done pulse.

Source files
------------

// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage, waits out BRAM latency then latches IR and splits it into fields
module lc3_decode #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_start,
  input  logic        flush,
  input  logic [15:0] mem_dout,
  output logic [15:0] ir_out,
  output logic [3:0]  opCode_out,
  output logic [2:0]  dr_out,
  output logic [2:0]  sr1_out,
  output logic [2:0]  sr2_out,
  output logic        imm_flag,
  output logic [15:0] imm5_sext,
  output logic [15:0] off6_sext,
  output logic [8:0]  off9_out,
  output logic [15:0] off9_sext,
  output logic [15:0] off11_sext,
  output logic [2:0]  br_nzp_out,
  output logic        illegal,
  output logic        busy,
  output logic        decode_done
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic        ill_q, ill_d, done_q, done_d, go, cap;
  // next-state: flush aborts a busy decode and beats a same-edge start; IR moves only on capture
  always_comb begin
    go      = state_q == IDLE && decode_start && !flush;
    cap     = state_q == WAIT && !flush && cnt_q == 3'(MEM_LAT);
    state_d = go ? WAIT : state_q == IDLE || flush || state_q == DONE ? IDLE : cap ? DONE : WAIT;
    cnt_d   = go ? 3'd1 : state_q == WAIT && !flush && !cap ? cnt_q + 3'd1 : 3'd0;
    ir_d    = cap ? mem_dout : ir_q;
    ill_d   = cap ? mem_dout[15:12] == 4'b1101 : ill_q;
    done_d  = cap;
  end
  // state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ir_q    <= 16'd0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
    end
  end
  assign ir_out      = ir_q;
  assign opCode_out  = ir_q[15:12];
  assign dr_out      = ir_q[11:9];
  assign sr1_out     = ir_q[8:6];
  assign sr2_out     = ir_q[2:0];
  assign imm_flag    = ir_q[5];
  assign imm5_sext   = {{11{ir_q[4]}}, ir_q[4:0]};
  assign off6_sext   = {{10{ir_q[5]}}, ir_q[5:0]};
  assign off9_out    = ir_q[8:0];
  assign off9_sext   = {{7{ir_q[8]}}, ir_q[8:0]};
  assign off11_sext  = {{5{ir_q[10]}}, ir_q[10:0]};
  assign br_nzp_out  = ir_q[15:12] == 4'b0000 ? ir_q[11:9] : 3'b000;
  assign illegal     = ill_q;
  assign busy        = state_q != IDLE;
  assign decode_done = done_q;
endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: directed checks of lc3_decode at MEM_LAT=1 (a_) and MEM_LAT=3 (b_)
module tb_lc3_decode;
  logic        clk = 0, rst = 1, decode_start = 0, flush = 0;
  logic [15:0] mem_dout = 0;
  logic [15:0] a_ir, a_imm5, a_off6, a_off9s, a_off11, b_ir, b_imm5, b_off6, b_off9s, b_off11;
  logic [3:0]  a_op, b_op;
  logic [2:0]  a_dr, a_sr1, a_sr2, a_nzp, b_dr, b_sr1, b_sr2, b_nzp;
  logic [8:0]  a_off9, b_off9;
  logic        a_imm, a_ill, a_busy, a_done, b_imm, b_ill, b_busy, b_done;
  int total = 0, bad = 0, hits, at;
  always #5 clk = ~clk;
  lc3_decode #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .decode_start(decode_start), .flush(flush), .mem_dout(mem_dout),
    .ir_out(a_ir), .opCode_out(a_op), .dr_out(a_dr), .sr1_out(a_sr1), .sr2_out(a_sr2),
    .imm_flag(a_imm), .imm5_sext(a_imm5), .off6_sext(a_off6), .off9_out(a_off9),
    .off9_sext(a_off9s), .off11_sext(a_off11), .br_nzp_out(a_nzp), .illegal(a_ill),
    .busy(a_busy), .decode_done(a_done));
  lc3_decode #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .decode_start(decode_start), .flush(flush), .mem_dout(mem_dout),
    .ir_out(b_ir), .opCode_out(b_op), .dr_out(b_dr), .sr1_out(b_sr1), .sr2_out(b_sr2),
    .imm_flag(b_imm), .imm5_sext(b_imm5), .off6_sext(b_off6), .off9_out(b_off9),
    .off9_sext(b_off9s), .off11_sext(b_off11), .br_nzp_out(b_nzp), .illegal(b_ill),
    .busy(b_busy), .decode_done(b_done));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one MEM_LAT=1 decode; returns with IR captured and decode_done sampled high
  task automatic run_a(input logic [15:0] w);
    @(negedge clk); decode_start = 1; mem_dout = w;
    @(negedge clk); decode_start = 0;
    chk("a_wait_busy", a_busy, 1); chk("a_wait_done", a_done, 0);
    @(negedge clk);
    chk("a_done", a_done, 1); chk("a_done_busy", a_busy, 1); chk("a_ir", a_ir, w);
  endtask
  initial begin
    repeat (5) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ir", a_ir, 0); chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0);
    chk("rst_off11", a_off11, 0); chk("rst_ill", a_ill, 0); chk("rst_b_ir", b_ir, 0);
    run_a(16'h0203);
    chk("br_op", a_op, 0); chk("br_nzp", a_nzp, 3'b001); chk("br_off9", a_off9, 9'h003);
    chk("br_off9s", a_off9s, 16'h0003);
    @(negedge clk);
    chk("br_done_drop", a_done, 0); chk("br_idle", a_busy, 0);
    run_a(16'h1A7F);
    chk("add_dr", a_dr, 5); chk("add_sr1", a_sr1, 1); chk("add_sr2", a_sr2, 7);
    chk("add_imm", a_imm, 1); chk("add_imm5", a_imm5, 16'hFFFF); chk("add_nzp", a_nzp, 0);
    chk("add_off6", a_off6, 16'hFFFF); chk("add_off11", a_off11, 16'h027F);
    run_a(16'h0FFF);
    chk("nbr_off9s", a_off9s, 16'hFFFF); chk("nbr_nzp", a_nzp, 3'b111); chk("nbr_off11", a_off11, 16'hFFFF);
    run_a(16'hD000);
    chk("ill_set", a_ill, 1); chk("ill_op", a_op, 4'hD);
    run_a(16'h0203);
    chk("ill_clr", a_ill, 0);
    @(negedge clk); decode_start = 1; flush = 1; mem_dout = 16'h5555;
    @(negedge clk); decode_start = 0; flush = 0;
    chk("flush_beats_start", a_busy, 0);
    repeat (2) @(negedge clk);
    chk("flush_idle_ir", a_ir, 16'h0203); chk("flush_idle_done", a_done, 0);
    rst = 1; @(negedge clk); rst = 0;
    // MEM_LAT=3: second start one cycle after the first is ignored
    decode_start = 1; mem_dout = 16'h3456;
    hits = 0; at = -1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      decode_start = i == 0;
      if (b_done) begin hits++; at = i; end
    end
    chk("lat3_hits", hits, 1); chk("lat3_at", at, 3); chk("lat3_ir", b_ir, 16'h3456);
    // flush at E0+2 aborts: no pulse, IR unchanged
    decode_start = 1; mem_dout = 16'h7777; hits = 0;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      decode_start = 0;
      flush = i == 1;
      if (b_done) hits++;
    end
    chk("flush_hits", hits, 0); chk("flush_ir", b_ir, 16'h3456); chk("flush_busy", b_busy, 0);
    // reset mid-WAIT
    decode_start = 1; mem_dout = 16'h1111;
    @(negedge clk); decode_start = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("mrst_busy", b_busy, 0); chk("mrst_ir", b_ir, 0); chk("mrst_done", b_done, 0);
    hits = 0;
    repeat (5) begin @(negedge clk); if (b_done) hits++; end
    chk("mrst_hits", hits, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
